spi_target: RTL and testbench
=============================

# spi_target

SPI target (slave) endpoint: receives frames clocked by an external SPI controller on SS_n/SCLK/MOSI and returns a response word on MISO. It sits behind an SoC peripheral register block, oversampling all SPI pins in the system clock domain, so no SPI-clocked flops exist. It matches our SPI controller's framing: MSB-first, 8- or 16-bit frames, selectable sampling edge.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for SS_n, SCLK and MOSI. Legal values are 2 or 3.

Ports:
- clk  in  1  system clock; all logic is on its rising edge
- rst_n  in  1  asynchronous active-low reset
- SS_n  in  1  target select from the controller, active low
- SCLK  in  1  serial clock from the controller
- MOSI  in  1  serial data from the controller
- MISO  out  1  serial data to the controller
- pos_edge  in  1  1: sample MOSI on rising SCLK and shift MISO on falling SCLK; 0: the reverse. Must be static while SS_n is low.
- width8  in  1  1: 8-bit frame; 0: 16-bit frame. Must be static while SS_n is low.
- tx_data  in  16  response word
- tx_load  in  1  writes tx_data into tx_buf
- rx_data  out  16  last completed frame; the upper byte is 0 in 8-bit mode
- rx_valid  out  1  level; set on frame completion, cleared by rx_ack
- rx_ack  in  1  consumer acknowledge
- overrun  out  1  sticky; a frame completed while rx_valid was still 1
- busy  out  1  1 while the FSM is not in IDLE

## Operation
- **Synchronizers.** SS_n, SCLK and MOSI each pass through SYNC_STAGES flops; the synchronized values are ss_s, sclk_s and mosi_s. One further flop holds sclk_d.
  - rise = sclk_s & ~sclk_d; fall = ~sclk_s & sclk_d.
  - sample_edge = pos_edge ? rise : fall; shift_edge is the other edge.
- **tx_buf.** A 16-bit register, reset 0, written by tx_load in any state. A load takes effect only at the next frame start; it never alters a frame in progress.
- **FSM states.** IDLE, SHIFT, WAIT_SS.
  - **IDLE:** MISO = 0 and busy = 0. On ss_s = 0, go to SHIFT. In that same cycle:
    - tx_sr <= tx_buf, or {tx_buf[7:0], 8'h00} when width8 = 1.
    - bit_cnt <= 0 and armed <= 0.
  - **SHIFT:** MISO = tx_sr[15].
    - On sample_edge: rx_sr <= {rx_sr[14:0], mosi_s}, bit_cnt++, armed <= 1.
    - On shift_edge with armed = 1: tx_sr <= tx_sr << 1. Shift edges before the first sample edge are ignored, which covers the leading idle-to-active SCLK transition.
    - When bit_cnt reaches 16, or 8 with width8 = 1:
      - rx_data <= rx_sr, or {8'h00, rx_sr[7:0]} in 8-bit mode.
      - rx_valid <= 1, and overrun <= 1 if rx_valid was already 1.
      - Go to WAIT_SS.
    - On ss_s = 1 before the count completes: abort. Discard rx_sr, leave rx_valid and rx_data unchanged, go to IDLE.
  - **WAIT_SS:** MISO holds its last bit. SCLK edges are ignored. On ss_s = 1, go to IDLE.
- **rx_valid / overrun priority.** rx_ack clears both rx_valid and overrun. If rx_ack and frame completion occur in the same cycle, completion wins: rx_valid = 1, and overrun is unchanged by that completion.
- **bit_cnt** is 5 bits wide and cannot wrap because the FSM leaves SHIFT at the terminal count.
- **Reset values (asynchronous, mid-frame included).** FSM = IDLE; all synchronizer flops = 1; sclk_d = 1; tx_buf, tx_sr, rx_sr and rx_data = 0; MISO, rx_valid, overrun, busy and bit_cnt = 0. A frame in progress at reset is lost. After reset is released, the FSM enters SHIFT only after ss_s is seen low, so asserting rst_n with SS_n already low starts a fresh frame immediately.

## Timing
- Pin-to-event latency: SYNC_STAGES+1 clk cycles from an SCLK pin edge to its rise/fall pulse.
- MISO is registered. It updates 1 cycle after the shift_edge pulse, i.e. SYNC_STAGES+2 clk cycles after the pin edge.
- SCLK high and low times must each be at least SYNC_STAGES+3 clk periods. With a matching controller this means clkdiv ≥ SYNC_STAGES+2.
- The first MISO bit is valid SYNC_STAGES+2 cycles after SS_n falls. The controller must wait at least that long before its first sample edge.
- rx_valid rises 1 cycle after the final sample_edge pulse.
- SS_n high time between frames must be at least SYNC_STAGES+2 clk cycles.

## Test plan
- **16-bit, pos_edge = 1, SCLK idle high, clkdiv = 7.** tx_load 0x3C5A, then a frame with MOSI = 0xA5C3 -> rx_data = 0xA5C3, rx_valid = 1, controller receives 0x3C5A, busy returns to 0 after SS_n rises.
- **8-bit, pos_edge = 0, SCLK idle low.** tx_data 0x0081, MOSI byte 0x7E -> rx_data = 0x007E, MISO bits 1,0,0,0,0,0,0,1.
- **Abort.** SS_n rises after 5 sample edges -> rx_valid stays 0, rx_data unchanged; the next full 16-bit frame 0x1234 is received correctly.
- **Overrun.** Two 16-bit frames 0x1111 then 0x2222 with no rx_ack -> rx_data = 0x2222, overrun = 1. Then rx_ack -> rx_valid = 0, overrun = 0. Also check that rx_ack in the same cycle as completion leaves rx_valid = 1.
- **tx_load mid-frame.** tx_load 0xFFFF during a frame loaded with 0x0000 -> the current frame returns 0x0000 and the next frame returns 0xFFFF.
- **Reset mid-frame.** Assert rst_n low after 9 bits -> all outputs 0 immediately. After release, a full frame 0xBEEF is received correctly.

Source files
------------

// File: rtl/spi_target.sv
// spi_target -- SPI target (slave) endpoint, fully oversampled in the clk domain.
//
// Receives MSB-first 8- or 16-bit frames from an external SPI controller and
// returns the word held in tx_buf on MISO. SS_n, SCLK and MOSI are brought into
// the clk domain through SYNC_STAGES-deep synchronizers. SCLK edges are then
// detected as single-cycle pulses, so there are no SPI-clocked flops.
//
// Ports:
//   clk, rst_n        system clock (rising edge), asynchronous active-low reset
//   SS_n, SCLK, MOSI  controller-driven SPI pins (asynchronous to clk)
//   MISO              registered serial response to the controller
//   pos_edge          1: sample MOSI on rising SCLK, shift on falling; 0: reverse
//   width8            1: 8-bit frames; 0: 16-bit frames
//   tx_data, tx_load  response word and its write strobe into tx_buf
//   rx_data           last completed frame (upper byte 0 in 8-bit mode)
//   rx_valid, rx_ack  frame-available level and its consumer acknowledge
//   overrun           sticky: a frame completed while rx_valid was still set
//   busy              FSM is outside IDLE
module spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        pos_edge,
  input  logic        width8,
  input  logic [15:0] tx_data,
  input  logic        tx_load,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_WAIT_SS = 2'd2
  } state_e;

  // Synchronizer chains; the MSB of each chain is the synchronized value.
  logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_d_q;

  logic ss_s, sclk_s, mosi_s;
  logic rise_s, fall_s, sample_edge_s, shift_edge_s;

  state_e      state_q,    state_d;
  logic [15:0] tx_buf_q,   tx_buf_d;
  logic [15:0] tx_sr_q,    tx_sr_d;
  logic [15:0] rx_sr_q,    rx_sr_d;
  logic [15:0] rx_data_q,  rx_data_d;
  logic [4:0]  bit_cnt_q,  bit_cnt_d;
  logic        armed_q,    armed_d;
  logic        miso_q,     miso_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q,  overrun_d;
  logic        busy_q,     busy_d;
  logic        frame_done_s;
  logic [4:0]  term_cnt_s;

  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign rise_s        = sclk_s & ~sclk_d_q;
  assign fall_s        = ~sclk_s & sclk_d_q;
  assign sample_edge_s = pos_edge ? rise_s : fall_s;
  assign shift_edge_s  = pos_edge ? fall_s : rise_s;
  assign term_cnt_s    = width8 ? 5'd8 : 5'd16;

  assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
  assign ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_n};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};

  // Pin synchronizers and the SCLK edge-detect delay flop.
  // They reset to all ones so an idle-high bus produces no edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= {SYNC_STAGES{1'b1}};
      sclk_sync_q <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= {SYNC_STAGES{1'b1}};
      sclk_d_q    <= 1'b1;
    end else begin
      ss_sync_q   <= ss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_d_q    <= sclk_s;
    end
  end

  // Next-state and datapath logic for the frame FSM.
  always_comb begin
    state_d      = state_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    rx_data_d    = rx_data_q;
    bit_cnt_d    = bit_cnt_q;
    armed_d      = armed_q;
    frame_done_s = 1'b0;

    // tx_buf only reaches the wire at the next frame start.
    if (tx_load) begin
      tx_buf_d = tx_data;
    end else begin
      tx_buf_d = tx_buf_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!ss_s) begin
          state_d   = ST_SHIFT;
          tx_sr_d   = width8 ? {tx_buf_q[7:0], 8'h00} : tx_buf_q;
          rx_sr_d   = 16'h0000;
          bit_cnt_d = 5'd0;
          armed_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (ss_s) begin
          // Aborted frame: partial data is dropped, rx_data/rx_valid untouched.
          state_d = ST_IDLE;
        end else if (sample_edge_s) begin
          rx_sr_d   = {rx_sr_q[14:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          armed_d   = 1'b1;
          if (bit_cnt_d == term_cnt_s) begin
            frame_done_s = 1'b1;
            state_d      = ST_WAIT_SS;
            rx_data_d    = width8 ? {8'h00, rx_sr_d[7:0]} : rx_sr_d;
          end else begin
            state_d = ST_SHIFT;
          end
        end else if (shift_edge_s && armed_q) begin
          // Unarmed shift edges are the leading idle-to-active transition.
          tx_sr_d = {tx_sr_q[14:0], 1'b0};
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_WAIT_SS: begin
        if (ss_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_SS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Completion has priority over rx_ack; a completion coinciding with an
    // acknowledge neither raises nor clears overrun.
    if (frame_done_s) begin
      rx_valid_d = 1'b1;
      if (rx_ack) begin
        overrun_d = overrun_q;
      end else begin
        overrun_d = overrun_q | rx_valid_q;
      end
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
      overrun_d  = overrun_q;
    end

    // MISO is registered from the next-cycle state so it tracks tx_sr[15].
    case (state_d)
      ST_IDLE:    miso_d = 1'b0;
      ST_SHIFT:   miso_d = tx_sr_d[15];
      ST_WAIT_SS: miso_d = miso_q;
      default:    miso_d = 1'b0;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Frame FSM state, shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_buf_q   <= 16'h0000;
      tx_sr_q    <= 16'h0000;
      rx_sr_q    <= 16'h0000;
      rx_data_q  <= 16'h0000;
      bit_cnt_q  <= 5'd0;
      armed_q    <= 1'b0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_buf_q   <= tx_buf_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      armed_q    <= armed_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target -- directed self-checking bench for spi_target.
// A behavioural SPI controller drives SS_n/SCLK/MOSI with a half period of
// HALF clk cycles. It shifts on the leading edge and samples MISO on the
// trailing edge. The SCLK idle level equals pos_edge.
module tb_spi_target;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;

  logic        clk;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic        pos_edge;
  logic        width8;
  logic [15:0] tx_data;
  logic        tx_load;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ack;
  logic        overrun;
  logic        busy;

  int          n_checks;
  int          n_fail;
  bit          mid_load_en;
  logic [15:0] mid_load_val;
  bit          ack_at_end;
  logic [15:0] miso_w;

  spi_target #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .pos_edge (pos_edge),
    .width8   (width8),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .overrun  (overrun),
    .busy     (busy)
  );

  // 100 MHz system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic load_tx(input logic [15:0] v);
    @(negedge clk);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  // Switch SCLK idle level/mode while SS_n is high.
  task automatic set_mode(input logic pe, input logic w8);
    @(negedge clk);
    pos_edge = pe;
    width8   = w8;
    SCLK     = pe;
    repeat (8) @(negedge clk);
  endtask

  // Controller: sends nbits of mosi_w (MSB of an flen-bit word first).
  task automatic spi_frame(input int flen, input int nbits, input logic [15:0] mosi_w,
                           input bit raise_ss, output logic [15:0] miso_o);
    miso_o = 16'h0000;
    SS_n   = 1'b0;
    MOSI   = mosi_w[flen-1];
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = ~pos_edge;
      if (i > 0) MOSI = mosi_w[flen-1-i];
      if (mid_load_en && i == 4) tx_data = mid_load_val;
      for (int c = 0; c < HALF; c++) begin
        tx_load = (mid_load_en && i == 4 && c == 1);
        @(negedge clk);
      end
      tx_load = 1'b0;
      SCLK    = pos_edge;
      miso_o  = {miso_o[14:0], MISO};
      for (int c = 0; c < HALF; c++) begin
        rx_ack = (ack_at_end && i == nbits - 1 && c == SYNC_STAGES);
        @(negedge clk);
      end
      rx_ack = 1'b0;
    end
    if (raise_ss) begin
      SS_n = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    mid_load_en  = 1'b0;
    mid_load_val = 16'h0000;
    ack_at_end   = 1'b0;
    rst_n        = 1'b0;
    SS_n         = 1'b1;
    SCLK         = 1'b1;
    MOSI         = 1'b0;
    pos_edge     = 1'b1;
    width8       = 1'b0;
    tx_data      = 16'h0000;
    tx_load      = 1'b0;
    rx_ack       = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_miso", {15'h0, MISO}, 16'h0000);
    check_eq("reset_rx_data", rx_data, 16'h0000);
    check_eq("reset_rx_valid", {15'h0, rx_valid}, 16'h0000);
    check_eq("reset_overrun", {15'h0, overrun}, 16'h0000);
    check_eq("reset_busy", {15'h0, busy}, 16'h0000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 16-bit frame, sample on rising SCLK, idle high.
    load_tx(16'h3C5A);
    spi_frame(16, 16, 16'hA5C3, 1'b1, miso_w);
    check_eq("t1_rx_data", rx_data, 16'hA5C3);
    check_eq("t1_rx_valid", {15'h0, rx_valid}, 16'h0001);
    check_eq("t1_miso", miso_w, 16'h3C5A);
    check_eq("t1_busy", {15'h0, busy}, 16'h0000);
    check_eq("t1_overrun", {15'h0, overrun}, 16'h0000);
    pulse_ack();
    check_eq("t1_ack_valid", {15'h0, rx_valid}, 16'h0000);

    // 8-bit frame, sample on falling SCLK, idle low.
    set_mode(1'b0, 1'b1);
    load_tx(16'h0081);
    spi_frame(8, 8, 16'h007E, 1'b1, miso_w);
    check_eq("t2_rx_data", rx_data, 16'h007E);
    check_eq("t2_miso", miso_w, 16'h0081);
    pulse_ack();

    // Abort after 5 sample edges, then a clean 16-bit frame.
    set_mode(1'b0, 1'b0);
    spi_frame(16, 5, 16'hFFFF, 1'b1, miso_w);
    check_eq("t3_abort_valid", {15'h0, rx_valid}, 16'h0000);
    check_eq("t3_abort_data", rx_data, 16'h007E);
    check_eq("t3_abort_busy", {15'h0, busy}, 16'h0000);
    spi_frame(16, 16, 16'h1234, 1'b1, miso_w);
    check_eq("t3_rx_data", rx_data, 16'h1234);
    check_eq("t3_rx_valid", {15'h0, rx_valid}, 16'h0001);
    pulse_ack();

    // Overrun: two frames without acknowledge.
    set_mode(1'b1, 1'b0);
    spi_frame(16, 16, 16'h1111, 1'b1, miso_w);
    check_eq("t4_first_overrun", {15'h0, overrun}, 16'h0000);
    spi_frame(16, 16, 16'h2222, 1'b1, miso_w);
    check_eq("t4_rx_data", rx_data, 16'h2222);
    check_eq("t4_overrun", {15'h0, overrun}, 16'h0001);
    check_eq("t4_rx_valid", {15'h0, rx_valid}, 16'h0001);
    pulse_ack();
    check_eq("t4_ack_valid", {15'h0, rx_valid}, 16'h0000);
    check_eq("t4_ack_overrun", {15'h0, overrun}, 16'h0000);
    // rx_ack in the completion cycle: completion wins.
    ack_at_end = 1'b1;
    spi_frame(16, 16, 16'h3333, 1'b1, miso_w);
    ack_at_end = 1'b0;
    check_eq("t4_same_cycle_valid", {15'h0, rx_valid}, 16'h0001);
    check_eq("t4_same_cycle_data", rx_data, 16'h3333);
    check_eq("t4_same_cycle_overrun", {15'h0, overrun}, 16'h0000);

    // tx_load mid-frame affects only the following frame.
    load_tx(16'h0000);
    mid_load_en  = 1'b1;
    mid_load_val = 16'hFFFF;
    spi_frame(16, 16, 16'h5555, 1'b1, miso_w);
    mid_load_en  = 1'b0;
    check_eq("t5_current_miso", miso_w, 16'h0000);
    spi_frame(16, 16, 16'hAAAA, 1'b1, miso_w);
    check_eq("t5_next_miso", miso_w, 16'hFFFF);

    // Reset after 9 bits with SS_n held low.
    spi_frame(16, 9, 16'h0F0F, 1'b0, miso_w);
    check_eq("t6_busy_before", {15'h0, busy}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_miso", {15'h0, MISO}, 16'h0000);
    check_eq("t6_rst_rx_data", rx_data, 16'h0000);
    check_eq("t6_rst_rx_valid", {15'h0, rx_valid}, 16'h0000);
    check_eq("t6_rst_overrun", {15'h0, overrun}, 16'h0000);
    check_eq("t6_rst_busy", {15'h0, busy}, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    spi_frame(16, 16, 16'hBEEF, 1'b1, miso_w);
    check_eq("t6_rx_data", rx_data, 16'hBEEF);
    check_eq("t6_rx_valid", {15'h0, rx_valid}, 16'h0001);
    check_eq("t6_miso_after_reset", miso_w, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
